// File: rtl/interrupt_sequencer_if.sv
// Bus bundle between the PIC sequencer, the IRR/IMR/command logic and the CPU side.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface interrupt_sequencer_if;
   logic [7:0] interruptRequest;
   logic [7:0] interruptMask;
   logic       interruptAcknowledge;
   logic [4:0] vectorBase;
   logic       autoEoi;
   logic       eoiNonSpecific;
   logic       eoiSpecific;
   logic [2:0] eoiLevel;
   logic       rotateOnEoi;
   logic       setPriority;
   logic [2:0] priorityLevel;
   logic       interruptOut;
   logic [7:0] clearInterruptRequest;
   logic [7:0] inServiceRegister;
   logic [7:0] dataOut;
   logic       dataOutEnable;

   modport master (
      output interruptRequest, interruptMask, interruptAcknowledge, vectorBase, autoEoi,
             eoiNonSpecific, eoiSpecific, eoiLevel, rotateOnEoi, setPriority, priorityLevel,
      input  interruptOut, clearInterruptRequest, inServiceRegister, dataOut, dataOutEnable
   );

   modport slave (
      input  interruptRequest, interruptMask, interruptAcknowledge, vectorBase, autoEoi,
             eoiNonSpecific, eoiSpecific, eoiLevel, rotateOnEoi, setPriority, priorityLevel,
      output interruptOut, clearInterruptRequest, inServiceRegister, dataOut, dataOutEnable
   );
endinterface

// File: rtl/interrupt_sequencer.sv
// Priority resolution and INTA sequencing for an 8259A-style interrupt controller:
// nested/rotating priority against the ISR, two-pulse acknowledge, EOI handling.
module interrupt_sequencer #(
   parameter int NUM_IRQ        = 8,
   parameter int SPURIOUS_LEVEL = 7
) (
   input logic                  clk,
   input logic                  reset,
   interrupt_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      ACK1    = 2'd2,
      ACK2    = 2'd3
   } stateType;

   localparam logic [2:0] SpuriousLevel = 3'(SPURIOUS_LEVEL);

   stateType   stateR, stateNext;
   logic       intaPrevR;
   logic       candArmedR, candArmedNext;
   logic       interruptOutR, interruptOutNext;
   logic [7:0] clearR, clearNext;
   logic [7:0] isrR, isrNext;
   logic [7:0] dataOutR, dataOutNext;
   logic       dataOutEnableR, dataOutEnableNext;
   logic [2:0] lowestR, lowestNext;
   logic [2:0] servicedR, servicedNext;
   logic       spuriousR, spuriousNext;

   logic       intaRiseS, intaFallS;
   logic [2:0] startLevelS, candLevelS, isrTopLevelS, eoiLevelS;
   logic [3:0] candHitS, isrHitS;
   logic       candValidS, eoiHitS, autoRotateS;
   logic [7:0] eoiClearS, autoClearS, setMaskS;

   // Bit k of the result is level (k + amt) mod 8, so bit 0 is the highest-priority level.
   function automatic logic [7:0] rotRight(input logic [7:0] v, input logic [2:0] amt);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < 8; k++) begin
         r[k] = v[3'(k) + amt];
      end
      return r;
   endfunction

   function automatic logic [3:0] firstSet(input logic [7:0] v);
      logic [3:0] hit;
      hit = 4'b0000;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         hit = v[i] ? {1'b1, 3'(i)} : hit;
      end
      return hit;
   endfunction

   // Priority resolution: ranks are distances from the slot after lowestPriority.
   always_comb begin
      intaRiseS    = bus.interruptAcknowledge & ~intaPrevR;
      intaFallS    = ~bus.interruptAcknowledge & intaPrevR;
      startLevelS  = lowestR + 3'd1;
      candHitS     = firstSet(rotRight(bus.interruptRequest & ~bus.interruptMask, startLevelS));
      isrHitS      = firstSet(rotRight(isrR, startLevelS));
      candLevelS   = candHitS[2:0] + startLevelS;
      isrTopLevelS = isrHitS[2:0] + startLevelS;
      candValidS   = candHitS[3] & (~isrHitS[3] | (candHitS[2:0] < isrHitS[2:0]));
      eoiLevelS    = bus.eoiSpecific ? bus.eoiLevel : isrTopLevelS;
      eoiHitS      = bus.eoiSpecific ? isrR[bus.eoiLevel] : (bus.eoiNonSpecific & isrHitS[3]);
      eoiClearS    = eoiHitS ? (8'h01 << eoiLevelS) : 8'h00;
   end

   // Handshake FSM next state plus next values of every registered output.
   always_comb begin
      stateNext         = stateR;
      candArmedNext     = 1'b0;
      interruptOutNext  = interruptOutR;
      clearNext         = 8'h00;
      dataOutNext       = dataOutR;
      dataOutEnableNext = dataOutEnableR;
      servicedNext      = servicedR;
      spuriousNext      = spuriousR;
      setMaskS          = 8'h00;
      autoClearS        = 8'h00;
      autoRotateS       = 1'b0;
      case (stateR)
         IDLE: begin
            candArmedNext = candValidS;
            if (candArmedR) begin
               interruptOutNext = 1'b1;
               stateNext        = PENDING;
            end else begin
               interruptOutNext = 1'b0;
            end
         end
         PENDING: begin
            if (intaRiseS) begin
               interruptOutNext = 1'b0;
               stateNext        = ACK1;
               if (candValidS) begin
                  setMaskS     = 8'h01 << candLevelS;
                  clearNext    = 8'h01 << candLevelS;
                  servicedNext = candLevelS;
                  spuriousNext = 1'b0;
               end else begin
                  servicedNext = SpuriousLevel;
                  spuriousNext = 1'b1;
               end
            end else begin
               interruptOutNext = 1'b1;
            end
         end
         ACK1: begin
            if (intaFallS) begin
               stateNext = ACK2;
            end else begin
               stateNext = ACK1;
            end
         end
         ACK2: begin
            if (intaRiseS) begin
               dataOutNext       = {bus.vectorBase, servicedR};
               dataOutEnableNext = 1'b1;
            end else if (intaFallS) begin
               dataOutEnableNext = 1'b0;
               stateNext         = IDLE;
               if (bus.autoEoi && !spuriousR) begin
                  autoClearS  = 8'h01 << servicedR;
                  autoRotateS = bus.rotateOnEoi;
               end else begin
                  autoClearS  = 8'h00;
               end
            end else begin
               stateNext = ACK2;
            end
         end
         default: begin
            stateNext        = IDLE;
            interruptOutNext = 1'b0;
         end
      endcase
      // A set in the same cycle as a clear of the same bit leaves the bit set.
      isrNext = (isrR & ~eoiClearS & ~autoClearS) | setMaskS;
      if (bus.setPriority) begin
         lowestNext = bus.priorityLevel;
      end else if (autoRotateS) begin
         lowestNext = servicedR;
      end else if (eoiHitS && bus.rotateOnEoi) begin
         lowestNext = eoiLevelS;
      end else begin
         lowestNext = lowestR;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateR         <= IDLE;
         intaPrevR      <= 1'b0;
         candArmedR     <= 1'b0;
         interruptOutR  <= 1'b0;
         clearR         <= 8'h00;
         isrR           <= 8'h00;
         dataOutR       <= 8'h00;
         dataOutEnableR <= 1'b0;
         lowestR        <= 3'd7;
         servicedR      <= SpuriousLevel;
         spuriousR      <= 1'b0;
      end else begin
         stateR         <= stateNext;
         intaPrevR      <= bus.interruptAcknowledge;
         candArmedR     <= candArmedNext;
         interruptOutR  <= interruptOutNext;
         clearR         <= clearNext;
         isrR           <= isrNext;
         dataOutR       <= dataOutNext;
         dataOutEnableR <= dataOutEnableNext;
         lowestR        <= lowestNext;
         servicedR      <= servicedNext;
         spuriousR      <= spuriousNext;
      end
   end

   assign bus.interruptOut          = interruptOutR;
   assign bus.clearInterruptRequest = clearR;
   assign bus.inServiceRegister     = isrR;
   assign bus.dataOut               = dataOutR;
   assign bus.dataOutEnable         = dataOutEnableR;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a behavioural PIC model.
module tb_interrupt_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   interrupt_sequencer_if bus ();
   interrupt_sequencer #(.NUM_IRQ(8), .SPURIOUS_LEVEL(7)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Model: handshake progress is a count of INTA edges seen since INT was raised.
   logic [7:0] mIsr, mClr, mDout;
   logic [2:0] mServ;
   logic       mInt, mDoe, mSpur, mArmed, mBusy, mPrevInta;
   int         mLow, mEdges;
   bit         modelLive = 1'b0;

   // Rank 0 is the highest priority: the level just after the lowest one.
   function automatic int rankOf(input int lvl, input int low);
      return (lvl - low + 7) % 8;
   endfunction

   function automatic int topLevel(input logic [7:0] v, input int low);
      for (int k = 1; k <= 8; k++) begin
         if (v[(low + k) % 8]) return (low + k) % 8;
      end
      return -1;
   endfunction

   function automatic int candidate(input logic [7:0] req, input logic [7:0] mask,
                                    input logic [7:0] isr, input int low);
      int c, t;
      c = topLevel(req & ~mask, low);
      t = topLevel(isr, low);
      if (c < 0) return -1;
      if (t >= 0 && rankOf(c, low) >= rankOf(t, low)) return -1;
      return c;
   endfunction

   task automatic modelStep();
      int cand, hitLvl, lowN;
      logic rise, fall, hit, armedN;
      logic [7:0] isrN;
      if (reset) begin
         mIsr = 8'h00; mClr = 8'h00; mDout = 8'h00; mServ = 3'd7; mInt = 1'b0; mDoe = 1'b0;
         mSpur = 1'b0; mArmed = 1'b0; mBusy = 1'b0; mPrevInta = 1'b0; mLow = 7; mEdges = 0;
         return;
      end
      rise   = bus.interruptAcknowledge && !mPrevInta;
      fall   = !bus.interruptAcknowledge && mPrevInta;
      cand   = candidate(bus.interruptRequest, bus.interruptMask, mIsr, mLow);
      isrN   = mIsr;
      lowN   = mLow;
      mClr   = 8'h00;
      armedN = 1'b0;
      hit    = 1'b0;
      hitLvl = 0;
      if (bus.eoiSpecific) begin
         hitLvl = int'(bus.eoiLevel);
         hit    = mIsr[hitLvl];
      end else if (bus.eoiNonSpecific) begin
         hitLvl = topLevel(mIsr, mLow);
         hit    = (hitLvl >= 0);
      end
      if (hit) begin
         isrN[hitLvl] = 1'b0;
         if (bus.rotateOnEoi) lowN = hitLvl;
      end
      if (!mBusy) begin
         if (mArmed) begin
            mInt = 1'b1; mBusy = 1'b1; mEdges = 0;
         end
         armedN = (cand >= 0);
      end else if (mEdges == 0) begin
         if (rise) begin
            mInt = 1'b0; mEdges = 1;
            if (cand >= 0) begin
               isrN[cand] = 1'b1; mClr[cand] = 1'b1; mServ = 3'(cand); mSpur = 1'b0;
            end else begin
               mServ = 3'd7; mSpur = 1'b1;
            end
         end
      end else if (mEdges == 1) begin
         if (fall) mEdges = 2;
      end else if (mEdges == 2) begin
         if (rise) begin
            mDout = {bus.vectorBase, mServ}; mDoe = 1'b1; mEdges = 3;
         end
      end else begin
         if (fall) begin
            mDoe = 1'b0; mBusy = 1'b0;
            if (bus.autoEoi && !mSpur) begin
               isrN[mServ] = 1'b0;
               if (bus.rotateOnEoi) lowN = int'(mServ);
            end
         end
      end
      if (bus.setPriority) lowN = int'(bus.priorityLevel);
      mIsr = isrN; mLow = lowN; mArmed = armedN; mPrevInta = bus.interruptAcknowledge;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all DUT outputs against the model.
   always @(negedge clk) begin
      if (modelLive) begin
         chk("model_int", 32'(bus.interruptOut), 32'(mInt));
         chk("model_clr", 32'(bus.clearInterruptRequest), 32'(mClr));
         chk("model_isr", 32'(bus.inServiceRegister), 32'(mIsr));
         chk("model_doe", 32'(bus.dataOutEnable), 32'(mDoe));
         chk("model_dout", 32'(bus.dataOut), 32'(mDout));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         modelStep();
         modelLive = 1'b1;
         @(negedge clk);
         bus.interruptRequest = bus.interruptRequest & ~mClr;
      end
   endtask

   task automatic handshake(input string tag, input logic [7:0] expVec,
                            input logic [7:0] expIsr, input logic [7:0] expClr);
      bus.interruptAcknowledge = 1'b1; tick();
      chk({tag, "_intDrop"}, 32'(bus.interruptOut), 32'h0);
      chk({tag, "_isrAck1"}, 32'(bus.inServiceRegister), 32'(expIsr));
      chk({tag, "_clrPulse"}, 32'(bus.clearInterruptRequest), 32'(expClr));
      bus.interruptAcknowledge = 1'b0; tick();
      chk({tag, "_clrGone"}, 32'(bus.clearInterruptRequest), 32'h0);
      bus.interruptAcknowledge = 1'b1; tick();
      chk({tag, "_vector"}, 32'(bus.dataOut), 32'(expVec));
      chk({tag, "_doeHigh"}, 32'(bus.dataOutEnable), 32'h1);
      bus.interruptAcknowledge = 1'b0; tick();
      chk({tag, "_doeLow"}, 32'(bus.dataOutEnable), 32'h0);
   endtask

   task automatic pulseEoi(input logic specific, input logic [2:0] lvl);
      bus.eoiSpecific = specific; bus.eoiNonSpecific = ~specific; bus.eoiLevel = lvl;
      tick();
      bus.eoiSpecific = 1'b0; bus.eoiNonSpecific = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.interruptRequest = 8'h00; bus.interruptMask = 8'h00; bus.interruptAcknowledge = 1'b0;
      bus.vectorBase = 5'h08; bus.autoEoi = 1'b0; bus.eoiNonSpecific = 1'b0;
      bus.eoiSpecific = 1'b0; bus.eoiLevel = 3'd0; bus.rotateOnEoi = 1'b0;
      bus.setPriority = 1'b0; bus.priorityLevel = 3'd0;
      tick(2);
      chk("rst_int", 32'(bus.interruptOut), 32'h0);
      chk("rst_isr", 32'(bus.inServiceRegister), 32'h0);
      chk("rst_dout", 32'(bus.dataOut), 32'h0);
      chk("rst_doe", 32'(bus.dataOutEnable), 32'h0);
      reset = 1'b0;

      // IR2 and IR5 together: IR2 wins, vector 0x42.
      bus.interruptRequest = 8'h24;
      tick();
      chk("t1_intEarly", 32'(bus.interruptOut), 32'h0);
      tick();
      chk("t1_intRaised", 32'(bus.interruptOut), 32'h1);
      handshake("t1", 8'h42, 8'h04, 8'h04);

      // IR1 nests over IR2; IR3 stays blocked until both higher levels finish.
      bus.interruptRequest = bus.interruptRequest | 8'h02;
      tick(2);
      chk("t2_intNested", 32'(bus.interruptOut), 32'h1);
      handshake("t2", 8'h41, 8'h06, 8'h02);
      bus.interruptRequest = bus.interruptRequest | 8'h08;
      tick(4);
      chk("t2_ir3Blocked", 32'(bus.interruptOut), 32'h0);
      pulseEoi(1'b0, 3'd0);
      chk("t2_isrAfterEoi", 32'(bus.inServiceRegister), 32'h04);
      tick(3);
      chk("t2_ir3StillBlocked", 32'(bus.interruptOut), 32'h0);
      bus.interruptRequest = 8'h00;
      pulseEoi(1'b0, 3'd0);
      chk("t2_isrCleared", 32'(bus.inServiceRegister), 32'h00);

      // Masked request, then a request that vanishes before INTA: spurious vector.
      bus.interruptMask = 8'h04; bus.interruptRequest = 8'h04;
      tick(4);
      chk("t3_masked", 32'(bus.interruptOut), 32'h0);
      bus.interruptMask = 8'h00;
      tick(2);
      chk("t3_intRaised", 32'(bus.interruptOut), 32'h1);
      bus.interruptRequest = 8'h00;
      handshake("t3", 8'h47, 8'h00, 8'h00);

      // Automatic EOI with rotation: IR0 becomes lowest, so IR1 beats IR0.
      bus.autoEoi = 1'b1; bus.rotateOnEoi = 1'b1; bus.interruptRequest = 8'h01;
      tick(2);
      handshake("t4a", 8'h40, 8'h01, 8'h01);
      chk("t4_isrAutoCleared", 32'(bus.inServiceRegister), 32'h00);
      bus.interruptRequest = 8'h03;
      tick(2);
      chk("t4_intRaised", 32'(bus.interruptOut), 32'h1);
      handshake("t4b", 8'h41, 8'h02, 8'h02);
      tick(2);
      handshake("t4c", 8'h40, 8'h01, 8'h01);
      bus.autoEoi = 1'b0; bus.rotateOnEoi = 1'b0;

      // Lowest priority forced to IR4: IR0 still ahead of IR3.
      bus.setPriority = 1'b1; bus.priorityLevel = 3'd4;
      tick();
      bus.setPriority = 1'b0;
      bus.interruptRequest = 8'h09;
      tick(2);
      handshake("t5", 8'h40, 8'h01, 8'h01);
      bus.interruptRequest = 8'h00;
      pulseEoi(1'b1, 3'd0);
      chk("t5_specificEoi", 32'(bus.inServiceRegister), 32'h00);

      // Reset in ACK1 aborts the handshake; the following INTA pulse is ignored.
      bus.interruptRequest = 8'h01;
      tick(2);
      bus.interruptAcknowledge = 1'b1; tick();
      chk("t6_isrInAck1", 32'(bus.inServiceRegister), 32'h01);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t6_rstInt", 32'(bus.interruptOut), 32'h0);
      chk("t6_rstIsr", 32'(bus.inServiceRegister), 32'h00);
      chk("t6_rstDout", 32'(bus.dataOut), 32'h00);
      chk("t6_rstDoe", 32'(bus.dataOutEnable), 32'h0);
      bus.interruptAcknowledge = 1'b0; tick();
      bus.interruptAcknowledge = 1'b1; tick();
      chk("t6_noDoe", 32'(bus.dataOutEnable), 32'h0);
      bus.interruptAcknowledge = 1'b0; tick();
      chk("t6_idleInt", 32'(bus.interruptOut), 32'h0);

      // Random traffic checked by the every-cycle comparison.
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 799) == 0);
         if ($urandom_range(0, 2) == 0) bus.interruptAcknowledge = ~bus.interruptAcknowledge;
         if ($urandom_range(0, 3) == 0)
            bus.interruptRequest = bus.interruptRequest | (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0)
            bus.interruptRequest = bus.interruptRequest & ~(8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) bus.interruptMask = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 63) == 0) bus.autoEoi = ~bus.autoEoi;
         if ($urandom_range(0, 63) == 0) bus.rotateOnEoi = ~bus.rotateOnEoi;
         if ($urandom_range(0, 99) == 0) bus.vectorBase = 5'($urandom);
         bus.eoiSpecific    = ($urandom_range(0, 15) == 0);
         bus.eoiNonSpecific = ($urandom_range(0, 15) == 0);
         bus.eoiLevel       = 3'($urandom);
         bus.setPriority    = ($urandom_range(0, 49) == 0);
         bus.priorityLevel  = 3'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Control and priority-resolution block of the 8259A-style PIC. Sits between the interrupt request register (IRR) and the CPU-side bus logic.
- Each cycle it resolves the highest-priority unmasked request against the in-service register (ISR) and raises INT.
- It sequences the two-pulse INTA handshake: sets the ISR bit, clears the IRR bit, drives the vector byte.
- It handles EOI commands, automatic EOI, and rotating priority.

Parameters:
- NUM_IRQ, 8, number of request lines (the logic is written for 8; the level field is 3 bits).
- SPURIOUS_LEVEL, 7, level reported when no eligible request exists at the first INTA.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- interruptRequest  input  8  latched requests from the IRR.
- interruptMask  input  8  IMR; bit set = level masked.
- interruptAcknowledge  input  1  CPU INTA, active-high level, synchronous to clk; the block detects rising and falling edges internally.
- vectorBase  input  5  upper five bits of the vector (ICW2 T7..T3).
- autoEoi  input  1  1 = ISR bit auto-cleared at end of second INTA.
- eoiNonSpecific  input  1  one-cycle command pulse: clear the highest-priority ISR bit.
- eoiSpecific  input  1  one-cycle command pulse: clear ISR bit eoiLevel.
- eoiLevel  input  3  level for eoiSpecific.
- rotateOnEoi  input  1  qualifies either EOI pulse; lowest priority becomes the cleared level.
- setPriority  input  1  one-cycle pulse: lowest priority becomes priorityLevel.
- priorityLevel  input  3  level for setPriority.
- interruptOut  output  1  INT to CPU.
- clearInterruptRequest  output  8  one-hot, one-cycle pulse to the IRR clear input.
- inServiceRegister  output  8  current ISR.
- dataOut  output  8  vector byte.
- dataOutEnable  output  1  high while dataOut is valid.

Behaviour:
- Reset values:
  - interruptOut=0, clearInterruptRequest=0, inServiceRegister=0, dataOut=0, dataOutEnable=0.
  - lowestPriority=7, so IR0 is highest. State=IDLE.
  - Reset mid-handshake aborts it; INTA edges after reset are ignored until the state returns to IDLE and INT is re-raised.
- Priority order:
  - Order is lowestPriority+1, +2, … wrapping mod 8, with lowestPriority itself last.
  - Eligible set = interruptRequest & ~interruptMask.
  - Fully nested mode: a candidate is valid only if its priority is strictly higher than the highest set ISR bit. Equal or lower priority is blocked.
- FSM states: IDLE, PENDING, ACK1, ACK2.
  - IDLE: when a valid candidate exists, set interruptOut=1 on the next edge and go to PENDING.
  - PENDING: interruptOut stays 1 even if the request drops (8259 behaviour).
    - On INTA rising edge, re-resolve the candidate and latch its level into servicedLevel.
    - If the candidate is valid: set ISR[level], pulse clearInterruptRequest[level] for exactly one cycle.
    - If no valid candidate: servicedLevel=SPURIOUS_LEVEL, no ISR set, no clear pulse.
    - interruptOut drops to 0 in the same cycle. Go to ACK1.
  - ACK1: on INTA falling edge, go to ACK2.
  - ACK2: on INTA rising edge, dataOut={vectorBase, servicedLevel} and dataOutEnable=1, held while INTA is high.
    - On INTA falling edge, dataOutEnable=0.
    - If autoEoi=1 and the request was not spurious, clear ISR[servicedLevel]; if rotateOnEoi=1, also set lowestPriority=servicedLevel.
    - Go to IDLE.
- Latency: request to interruptOut is 2 cycles from the IRR bit being set (1 edge to resolve, 1 to register). Vector is valid the cycle after the second INTA rising edge is sampled.
- EOI commands:
  - Accepted in any state.
  - Non-specific EOI clears the highest-priority set ISR bit; it is a no-op when the ISR is 0.
  - Specific EOI clears ISR[eoiLevel].
  - With rotateOnEoi=1, lowestPriority is set to the cleared level (rotation skipped if nothing was cleared).
  - Both EOI pulses in the same cycle: specific wins.
- Simultaneous events:
  - An EOI and an ISR set in the same cycle are both applied. If they target the same bit, the set wins.
  - setPriority together with a rotating EOI: setPriority wins.
  - Resolution in the cycle after an EOI uses the updated ISR and priority.

Test Plan:
1. Reset, mask=0x00, interruptRequest=0x24 (IR2, IR5) -> interruptOut=1 after 2 cycles. First INTA: ISR=0x04, clearInterruptRequest=0x04 for one cycle. Second INTA: dataOut=0x42 with vectorBase=0x08.
2. ISR=0x04 after test 1, then IR1 requested -> INT re-asserted, nested service sets ISR=0x06. IR3 requested -> no INT until eoiNonSpecific clears bit1 (then ISR=0x04, IR3 still blocked by IR2).
3. Mask=0x04 with interruptRequest=0x04 -> interruptOut stays 0. Remove the request between INT and first INTA -> dataOut={vectorBase,3'b111}, ISR unchanged, no clear pulse.
4. autoEoi=1, rotateOnEoi=1, IR0 serviced -> ISR=0x00 after second INTA falls, lowestPriority=0. Simultaneous IR0+IR1 -> IR1 serviced first.
5. setPriority with priorityLevel=4 and requests 0x09 (IR0, IR3) -> IR0 serviced first (IR5 now highest, IR4 lowest). eoiSpecific with eoiLevel=0 clears ISR=0x01 to 0x00.
6. Assert reset during ACK1 -> all outputs 0, ISR=0, state IDLE. The following INTA pulse produces no dataOutEnable.
